txll_arb: RTL and testbench

Frame-atomic arbiter in the `sys_clk` domain that shares the transmit link-layer FIFO write port (`txfifo_*`) between two frame sources. Requester 0 is the command/control FIS source and requester 1 is the data FIS source. The block grants one whole frame at a time using round-robin, throttles on `txfifo_almost_full`, and limits how many complete frames may sit in the FIFO, using `txfifo_eof_poped` as the frame-consumed indication.

---
 rtl/txll_arb_if.sv | 55 +++++
 rtl/txll_arb.sv | 143 ++++++++++++++
 tb/tb_txll_arb.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/txll_arb_if.sv
// ---------------------------------------------------------------------------
// txll_arb_if
// Bundles the two frame-source handshakes, the transmit FIFO write port and
// the arbiter status outputs into one interface.
//   slave  : arbiter side (accepts requester words, drives the FIFO port)
//   master : environment side (requesters, FIFO, status observer)
// Signals:
//   req{0,1}_valid/data/sof/eof  requester word and frame markers
//   req{0,1}_ready               word accepted when valid & ready
//   txfifo_data/sof/eof/wr_en    registered FIFO write port
//   txfifo_almost_full           FIFO headroom below threshold
//   txfifo_eof_poped             one-cycle pulse, one frame consumed
//   grant                        one-hot owner of the current frame
//   frames_out                   frames written but not yet popped
//   err_proto                    per-requester dropped/bad-word pulse
// ---------------------------------------------------------------------------
interface txll_arb_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_sof;
  logic        req0_eof;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_sof;
  logic        req1_eof;
  logic        req1_ready;
  logic [31:0] txfifo_data;
  logic        txfifo_sof;
  logic        txfifo_eof;
  logic        txfifo_wr_en;
  logic        txfifo_almost_full;
  logic        txfifo_eof_poped;
  logic [1:0]  grant;
  logic [2:0]  frames_out;
  logic [1:0]  err_proto;

  modport slave (
    input  req0_valid, req0_data, req0_sof, req0_eof,
    input  req1_valid, req1_data, req1_sof, req1_eof,
    input  txfifo_almost_full, txfifo_eof_poped,
    output req0_ready, req1_ready,
    output txfifo_data, txfifo_sof, txfifo_eof, txfifo_wr_en,
    output grant, frames_out, err_proto
  );

  modport master (
    output req0_valid, req0_data, req0_sof, req0_eof,
    output req1_valid, req1_data, req1_sof, req1_eof,
    output txfifo_almost_full, txfifo_eof_poped,
    input  req0_ready, req1_ready,
    input  txfifo_data, txfifo_sof, txfifo_eof, txfifo_wr_en,
    input  grant, frames_out, err_proto
  );
endinterface

// File: rtl/txll_arb.sv
// ---------------------------------------------------------------------------
// txll_arb
// Frame-atomic round-robin arbiter sharing the transmit link-layer FIFO write
// port between the command FIS source (requester 0) and the data FIS source
// (requester 1). A whole frame is granted at a time, words are throttled on
// txfifo_almost_full, and no new frame is admitted while C_MAX_FRAMES complete
// frames sit in the FIFO unconsumed.
// Ports:
//   sys_clk  single clock
//   sys_rst  asynchronous active-high reset
//   bus      txll_arb_if.slave (requester handshakes, FIFO port, status)
// Parameters:
//   C_MAX_FRAMES  max outstanding frames, 1..7
// ---------------------------------------------------------------------------
module txll_arb #(
  parameter int C_MAX_FRAMES = 2
) (
  input logic       sys_clk,
  input logic       sys_rst,
  txll_arb_if.slave bus
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_owner_q, last_owner_d;
  logic        first_q, first_d;          // next accepted word opens the frame
  logic [2:0]  frames_q;
  logic [1:0]  err_q, err_d;
  logic [31:0] wr_data_q;
  logic        wr_sof_q, wr_eof_q, wr_en_q;

  logic [1:0]  valid, sof, eof, cand, rdy;
  logic        owner, admit, acc, inc, pick;
  logic [31:0] own_data;

  assign valid    = {bus.req1_valid, bus.req0_valid};
  assign sof      = {bus.req1_sof,   bus.req0_sof};
  assign eof      = {bus.req1_eof,   bus.req0_eof};
  assign cand     = valid & sof;
  assign owner    = grant_q[1];
  assign own_data = owner ? bus.req1_data : bus.req0_data;
  assign admit    = !bus.txfifo_almost_full && (frames_q < 3'(C_MAX_FRAMES));
  // On a tie the requester that did not own the previous frame wins.
  assign pick     = (cand == 2'b11) ? ~last_owner_q : cand[1];
  assign inc      = acc && eof[owner];

  // NOTE: every always_comb output is assigned a default first so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    first_d      = first_q;
    rdy          = 2'b00;
    err_d        = 2'b00;
    acc          = 1'b0;
    case (state_q)
      IDLE: begin
        // Mid-frame words with no owner are drained and flagged, independent
        // of FIFO headroom, so a broken source can never wedge the port.
        for (int i = 0; i < 2; i++) begin
          if (valid[i] && !sof[i]) begin
            rdy[i]   = 1'b1;
            err_d[i] = 1'b1;
          end
        end
        if (admit && (cand != 2'b00)) begin
          grant_d      = pick ? 2'b10 : 2'b01;
          last_owner_d = pick;
          first_d      = 1'b1;
          state_d      = XFER;
        end
      end
      XFER: begin
        rdy = grant_q & {2{!bus.txfifo_almost_full}};
        acc = |(rdy & valid);
        if (acc) begin
          first_d = 1'b0;
          if (sof[owner] && !first_q) err_d[owner] = 1'b1;
          if (eof[owner]) begin
            grant_d = 2'b00;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      first_q      <= 1'b0;
      err_q        <= 2'b00;
      wr_data_q    <= 32'h0;
      wr_sof_q     <= 1'b0;
      wr_eof_q     <= 1'b0;
      wr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      first_q      <= first_d;
      err_q        <= err_d;
      wr_en_q      <= acc;
      wr_sof_q     <= acc && sof[owner];
      wr_eof_q     <= acc && eof[owner];
      if (acc) wr_data_q <= own_data;
    end
  end

  // Outstanding-frame counter; a pop with nothing outstanding is ignored.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frames_q <= 3'd0;
    end else begin
      case ({inc, bus.txfifo_eof_poped})
        2'b10:   frames_q <= frames_q + 3'd1;
        2'b01:   if (frames_q != 3'd0) frames_q <= frames_q - 3'd1;
        default: frames_q <= frames_q;
      endcase
    end
  end

  // Ready is combinational; it is forced low while reset is held so nothing
  // is handshaken into a block that is discarding state.
  assign bus.req0_ready   = rdy[0] && !sys_rst;
  assign bus.req1_ready   = rdy[1] && !sys_rst;
  assign bus.txfifo_data  = wr_data_q;
  assign bus.txfifo_sof   = wr_sof_q;
  assign bus.txfifo_eof   = wr_eof_q;
  assign bus.txfifo_wr_en = wr_en_q;
  assign bus.grant        = grant_q;
  assign bus.frames_out   = frames_q;
  assign bus.err_proto    = err_q;

endmodule

// File: tb/tb_txll_arb.sv
// ---------------------------------------------------------------------------
// tb_txll_arb
// Directed bench for txll_arb with C_MAX_FRAMES = 2. Accepted words are
// pushed to a scoreboard queue at the handshake and popped/compared when the
// FIFO write port fires.
// ---------------------------------------------------------------------------
module tb_txll_arb;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  txll_arb_if bus ();

  txll_arb #(.C_MAX_FRAMES(2)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } wr_t;

  wr_t sb[$];
  int  checks  = 0;
  int  errors  = 0;
  int  cyc     = 0;
  int  acc_cnt = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every FIFO write must match the oldest accepted word.
  always @(negedge sys_clk) begin
    if (!sys_rst && bus.txfifo_wr_en) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1'b1, 1'b0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check("wr_data", bus.txfifo_data, w.data);
        check("wr_sof",  bus.txfifo_sof,  w.sof);
        check("wr_eof",  bus.txfifo_eof,  w.eof);
      end
    end
  end

  task automatic drive(input int r, input logic v, input logic [31:0] d,
                       input logic s, input logic e);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_sof = s; bus.req0_eof = e;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_sof = s; bus.req1_eof = e;
    end
  endtask

  function automatic logic ready_of(input int r);
    return (r == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Present one word, wait (bounded) for the handshake, record it.
  task automatic put_word(input int r, input logic [31:0] d, input logic s,
                          input logic e, output int acc_cyc);
    int  budget = 0;
    wr_t w;
    drive(r, 1'b1, d, s, e);
    @(negedge sys_clk);
    while (!ready_of(r) && budget < 50) begin
      budget++;
      @(negedge sys_clk);
    end
    if (!ready_of(r)) begin
      check("handshake_timeout", ready_of(r), 1'b1);
      acc_cyc = -1;
    end else begin
      w.data = d; w.sof = s; w.eof = e;
      sb.push_back(w);
      acc_cyc = cyc;
      acc_cnt++;
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic send_frame(input int r, input logic [31:0] base, input int n,
                            output int first_c, output int last_c);
    int c;
    first_c = -1;
    last_c  = -1;
    for (int i = 0; i < n; i++) begin
      put_word(r, base + 32'(i), i == 0, i == n - 1, c);
      if (i == 0) first_c = c;
      last_c = c;
    end
    drive(r, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic pop_pulse();
    bus.txfifo_eof_poped = 1'b1;
    @(posedge sys_clk); #1;
    bus.txfifo_eof_poped = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"},  bus.grant,        2'b00);
    check({tag, "_frames"}, bus.frames_out,   3'd0);
    check({tag, "_wr_en"},  bus.txfifo_wr_en, 1'b0);
    check({tag, "_sof"},    bus.txfifo_sof,   1'b0);
    check({tag, "_eof"},    bus.txfifo_eof,   1'b0);
    check({tag, "_data"},   bus.txfifo_data,  32'h0);
    check({tag, "_err"},    bus.err_proto,    2'b00);
    check({tag, "_rdy0"},   bus.req0_ready,   1'b0);
    check({tag, "_rdy1"},   bus.req1_ready,   1'b0);
  endtask

  task automatic reset_dut(input string tag);
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge sys_clk); #1;
    sys_rst = 1'b1;
    #1;
    check_reset_values(tag);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    sb.delete();
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, l0, f1, l1, fb, lb, c, start, budget;
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    bus.txfifo_almost_full = 1'b0;
    bus.txfifo_eof_poped   = 1'b0;

    // Power-on reset.
    #3 sys_rst = 1'b1;
    #1 check_reset_values("por");
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Single 5-word frame from req0.
    drive(0, 1'b1, 32'hA000_0001, 1'b1, 1'b0);
    @(posedge sys_clk); #1;
    check("t1_grant", bus.grant, 2'b01);
    send_frame(0, 32'hA000_0001, 5, f0, l0);
    check("t1_consecutive", 32'(l0 - f0), 32'd4);
    repeat (2) begin @(posedge sys_clk); #1; end
    check("t1_frames", bus.frames_out, 3'd1);
    check("t1_grant_idle", bus.grant, 2'b00);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Tie after reset: req0 first, then req1 wins the re-presented tie,
    // and req0's second frame waits for a pop.
    reset_dut("rst_t2");
    fork
      begin
        send_frame(0, 32'hB000_0001, 2, f0, l0);
        send_frame(0, 32'hB100_0001, 2, fb, lb);
      end
      send_frame(1, 32'hC000_0001, 2, f1, l1);
      begin
        @(posedge sys_clk); #1;
        check("t2_grant_first", bus.grant, 2'b01);
      end
      begin
        budget = 0;
        while (bus.frames_out != 3'd2 && budget < 100) begin
          @(posedge sys_clk); #2;
          budget++;
        end
        check("t2_frames_full", bus.frames_out, 3'd2);
        pop_pulse();
      end
    join
    check("t2_req1_after_eof", 32'(f1 - l0), 32'd2);
    check("t2_req0b_after_req1", 32'(fb > l1), 32'd1);
    @(posedge sys_clk); #1;
    check("t2_frames_end", bus.frames_out, 3'd2);
    pop_pulse();
    pop_pulse();
    check("t2_frames_drained", bus.frames_out, 3'd0);

    // Frame limit: two 1-word frames outstanding block a third.
    send_frame(0, 32'hD000_0001, 1, f0, l0);
    send_frame(0, 32'hD000_0002, 1, f0, l0);
    check("t3_frames2", bus.frames_out, 3'd2);
    drive(1, 1'b1, 32'hE000_0001, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("t3_held_ready", bus.req1_ready, 1'b0);
      check("t3_held_grant", bus.grant, 2'b00);
      @(posedge sys_clk); #1;
    end
    pop_pulse();
    check("t3_frames_popped", bus.frames_out, 3'd1);
    check("t3_grant_pending", bus.grant, 2'b00);
    @(posedge sys_clk); #1;
    check("t3_grant_after_pop", bus.grant, 2'b10);
    put_word(1, 32'hE000_0001, 1'b1, 1'b1, c);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge sys_clk); #1;
    check("t3_frames_end", bus.frames_out, 3'd2);
    pop_pulse();
    pop_pulse();
    check("t3_frames_drained", bus.frames_out, 3'd0);

    // Almost-full stall after word 2 of a 6-word frame, held 4 cycles.
    start = acc_cnt;
    fork
      send_frame(0, 32'hF000_0001, 6, f0, l0);
      begin
        budget = 0;
        while (acc_cnt < start + 2 && budget < 100) begin
          @(posedge sys_clk); #2;
          budget++;
        end
        check("t4_af_sync", 32'(acc_cnt), 32'(start + 2));
        bus.txfifo_almost_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge sys_clk);
          check("t4_stall_ready", bus.req0_ready, 1'b0);
          @(posedge sys_clk); #2;
        end
        bus.txfifo_almost_full = 1'b0;
      end
    join
    repeat (2) begin @(posedge sys_clk); #1; end
    check("t4_words", 32'(acc_cnt - start), 32'd6);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    check("t4_frames", bus.frames_out, 3'd1);

    // Stray mid-frame word from req1 while idle.
    drive(1, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("t5_drain_ready", bus.req1_ready, 1'b1);
    @(posedge sys_clk); #1;
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t5_err_pulse", bus.err_proto, 2'b10);
    check("t5_no_write", bus.txfifo_wr_en, 1'b0);
    @(posedge sys_clk); #1;
    check("t5_err_clear", bus.err_proto, 2'b00);
    check("t5_no_write2", bus.txfifo_wr_en, 1'b0);

    // Pop coinciding with an accepted eof, then reset mid-frame.
    put_word(0, 32'h6000_0001, 1'b1, 1'b0, c);
    bus.txfifo_eof_poped = 1'b1;
    put_word(0, 32'h6000_0002, 1'b0, 1'b1, c);
    bus.txfifo_eof_poped = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t6_pop_eof_same", bus.frames_out, 3'd1);
    @(posedge sys_clk); #1;
    put_word(0, 32'h7000_0001, 1'b1, 1'b0, c);
    drive(0, 1'b1, 32'h7000_0002, 1'b0, 1'b0);
    @(negedge sys_clk); #1;
    sys_rst = 1'b1;
    #1;
    check_reset_values("t6_mid_rst");
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check("t6_post_grant", bus.grant, 2'b00);
    check("t6_post_frames", bus.frames_out, 3'd0);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
